ioctl_rom_router: RTL and testbench

- Parametrised successor to the core's ROM loader.
- Takes the host's ioctl byte stream and counts bytes internally.
- Bytes in the first SDR_BYTES of the stream are packed into 16-bit words and written to an SDRAM write channel (ch3 write side). A partial trailing word is flushed with byte enables.
- The remaining bytes are routed to NUM_BRAM on-chip BRAM regions of configurable size.
- Back-pressures the host through ioctl_wait and reports completion and overflow or protocol errors.

---
 rtl/xain_pkg.sv | 37 +++
 rtl/rom_region_decode.sv | 46 ++++
 rtl/ioctl_rom_router.sv | 223 ++++++++++++++++++++++
 tb/tb_ioctl_rom_router.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xain_pkg.sv
// Shared types, constants and region-map helpers for the ROM download path.
// The helpers are constant functions over a packed vector of region sizes.
package xain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SDR_WR,
    ST_FLUSH,
    ST_DONE
  } loader_state_t;

  // Wide enough for up to 8 regions of up to 32-bit sizes.
  localparam int REGION_VEC_W = 256;

  localparam int XAIN_NUM_BRAM    = 6;
  localparam int XAIN_BRAM_ADDR_W = 20;
  localparam logic [XAIN_NUM_BRAM*XAIN_BRAM_ADDR_W-1:0] XAIN_BRAM_BYTES = {
    20'h08000, 20'h08000, 20'h04000, 20'h04000, 20'h02000, 20'h02000
  };

  function automatic logic [63:0] region_size(input logic [REGION_VEC_W-1:0] sizes,
                                              input int aw, input int idx);
    logic [REGION_VEC_W-1:0] mask;
    mask = (REGION_VEC_W'(1) << aw) - REGION_VEC_W'(1);
    return 64'((sizes >> (idx * aw)) & mask);
  endfunction

  function automatic logic [63:0] region_base(input logic [REGION_VEC_W-1:0] sizes,
                                              input int aw, input int idx);
    logic [63:0] sum;
    sum = '0;
    for (int k = 0; k < idx; k++) sum += region_size(sizes, aw, k);
    return sum;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational map of a stream position onto SDRAM, one BRAM region, or past the end.
module rom_region_decode
  import xain_pkg::*;
#(
  parameter int                               ADDR_W      = 25,
  parameter logic [ADDR_W-1:0]                SDR_BYTES   = 25'h040000,
  parameter int                               NUM_BRAM    = 4,
  parameter int                               BRAM_ADDR_W = 20,
  parameter logic [NUM_BRAM*BRAM_ADDR_W-1:0]  BRAM_BYTES  = {4{20'h04000}}
) (
  input  logic [ADDR_W-1:0]      i_pos,
  output logic                   o_sdr,
  output logic                   o_hit,
  output logic [NUM_BRAM-1:0]    o_cs,
  output logic [BRAM_ADDR_W-1:0] o_offset,
  output logic                   o_over
);

  localparam logic [REGION_VEC_W-1:0] SIZES = REGION_VEC_W'(BRAM_BYTES);

  logic [63:0] w_rel;
  logic [63:0] w_base;
  logic [63:0] w_size;

  assign o_sdr  = (i_pos < SDR_BYTES);
  assign w_rel  = 64'(i_pos) - 64'(SDR_BYTES);
  assign o_over = !o_sdr && !o_hit;

  always_comb begin
    o_hit    = 1'b0;
    o_cs     = '0;
    o_offset = '0;
    w_base   = '0;
    w_size   = '0;
    for (int i = 0; i < NUM_BRAM; i++) begin
      w_base = region_base(SIZES, BRAM_ADDR_W, i);
      w_size = region_size(SIZES, BRAM_ADDR_W, i);
      if (!o_sdr && (w_rel >= w_base) && (w_rel < w_base + w_size)) begin
        o_hit    = 1'b1;
        o_cs[i]  = 1'b1;
        o_offset = BRAM_ADDR_W'(w_rel - w_base);
      end
    end
  end

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes the host ioctl byte stream: head packed into 16-bit SDRAM writes, tail into BRAM regions.
// Host is stalled via ioctl_wait only while an SDRAM write is outstanding.
module ioctl_rom_router
  import xain_pkg::*;
#(
  parameter int                               ADDR_W      = 25,
  parameter logic [ADDR_W-1:0]                SDR_BYTES   = 25'h040000,
  parameter int                               NUM_BRAM    = 4,
  parameter int                               BRAM_ADDR_W = 20,
  parameter logic [NUM_BRAM*BRAM_ADDR_W-1:0]  BRAM_BYTES  = {4{20'h04000}},
  parameter bit                               SWAP_BYTES  = 1'b0
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_data,
  output logic                   ioctl_wait,
  output logic [ADDR_W-1:0]      sdr_addr,
  output logic [15:0]            sdr_data,
  output logic [1:0]             sdr_be,
  output logic                   sdr_req,
  input  logic                   sdr_rdy,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [7:0]             bram_data,
  output logic [NUM_BRAM-1:0]    bram_cs,
  output logic                   bram_wr,
  output logic                   done,
  output logic                   overflow,
  output logic                   proto_err
);

  localparam logic [ADDR_W-1:0] POS_MAX = '1;

  loader_state_t          r_state, w_state_nxt;
  logic                   r_dl_q;
  logic [ADDR_W-1:0]      r_pos, w_pos_nxt;
  logic                   r_pend, w_pend_nxt;
  logic [7:0]             r_pend_byte, w_pend_byte_nxt;
  logic [ADDR_W-1:0]      r_sdr_addr, w_sdr_addr_nxt;
  logic [15:0]            r_sdr_data, w_sdr_data_nxt;
  logic [1:0]             r_sdr_be, w_sdr_be_nxt;
  logic                   r_sdr_req, w_sdr_req_nxt;
  logic                   r_wait, w_wait_nxt;
  logic [BRAM_ADDR_W-1:0] r_bram_addr, w_bram_addr_nxt;
  logic [7:0]             r_bram_data, w_bram_data_nxt;
  logic [NUM_BRAM-1:0]    r_bram_cs, w_bram_cs_nxt;
  logic                   r_bram_wr, w_bram_wr_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_overflow, w_overflow_nxt;
  logic                   r_proto_err, w_proto_err_nxt;

  logic                   w_rise, w_in_collect, w_accept, w_proto;
  logic [ADDR_W-1:0]      w_pos_cur;
  logic                   w_sdr, w_hit, w_over;
  logic [NUM_BRAM-1:0]    w_cs;
  logic [BRAM_ADDR_W-1:0] w_offset;

  // A strobe on the rising edge of download is decoded as the byte at position 0.
  assign w_rise       = ioctl_download & ~r_dl_q;
  assign w_pos_cur    = w_rise ? '0 : r_pos;
  assign w_in_collect = w_rise | ((r_state == ST_COLLECT) & ioctl_download);
  assign w_accept     = ioctl_wr & w_in_collect & (w_rise | ~r_wait);
  assign w_proto      = ioctl_wr & r_wait & ~w_rise;

  rom_region_decode #(
    .ADDR_W      (ADDR_W),
    .SDR_BYTES   (SDR_BYTES),
    .NUM_BRAM    (NUM_BRAM),
    .BRAM_ADDR_W (BRAM_ADDR_W),
    .BRAM_BYTES  (BRAM_BYTES)
  ) u_decode (
    .i_pos    (w_pos_cur),
    .o_sdr    (w_sdr),
    .o_hit    (w_hit),
    .o_cs     (w_cs),
    .o_offset (w_offset),
    .o_over   (w_over)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_pend_nxt      = r_pend;
    w_pend_byte_nxt = r_pend_byte;
    w_sdr_addr_nxt  = r_sdr_addr;
    w_sdr_data_nxt  = r_sdr_data;
    w_sdr_be_nxt    = r_sdr_be;
    w_sdr_req_nxt   = r_sdr_req;
    w_wait_nxt      = r_wait;
    w_bram_addr_nxt = r_bram_addr;
    w_bram_data_nxt = r_bram_data;
    w_bram_cs_nxt   = '0;
    w_bram_wr_nxt   = 1'b0;
    w_done_nxt      = r_done;
    w_overflow_nxt  = r_overflow;
    w_proto_err_nxt = r_proto_err;

    if (w_rise) begin
      w_state_nxt     = ST_COLLECT;
      w_pos_nxt       = '0;
      w_pend_nxt      = 1'b0;
      w_sdr_req_nxt   = 1'b0;
      w_wait_nxt      = 1'b0;
      w_done_nxt      = 1'b0;
      w_overflow_nxt  = 1'b0;
      w_proto_err_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: if (!ioctl_download) w_state_nxt = ST_FLUSH;
        ST_SDR_WR: begin
          if (sdr_rdy) begin
            w_sdr_req_nxt = 1'b0;
            w_wait_nxt    = 1'b0;
            w_state_nxt   = ioctl_download ? ST_COLLECT : ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (r_sdr_req) begin
            if (sdr_rdy) begin
              w_sdr_req_nxt = 1'b0;
              w_wait_nxt    = 1'b0;
              w_pend_nxt    = 1'b0;
              w_done_nxt    = 1'b1;
              w_state_nxt   = ST_DONE;
            end
          end else if (r_pend) begin
            // r_pos is odd here, so clearing bit 0 addresses the orphaned even byte.
            w_sdr_addr_nxt = {r_pos[ADDR_W-1:1], 1'b0};
            w_sdr_data_nxt = SWAP_BYTES ? {r_pend_byte, 8'h00} : {8'h00, r_pend_byte};
            w_sdr_be_nxt   = SWAP_BYTES ? 2'b10 : 2'b01;
            w_sdr_req_nxt  = 1'b1;
            w_wait_nxt     = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
        default: ;
      endcase
      if (w_proto) w_proto_err_nxt = 1'b1;
    end

    if (w_accept) begin
      w_pos_nxt = (w_pos_cur == POS_MAX) ? POS_MAX : w_pos_cur + 1'b1;
      if (w_sdr) begin
        if (!w_pos_cur[0]) begin
          w_pend_nxt      = 1'b1;
          w_pend_byte_nxt = ioctl_data;
        end else begin
          w_sdr_addr_nxt = {w_pos_cur[ADDR_W-1:1], 1'b0};
          w_sdr_data_nxt = SWAP_BYTES ? {r_pend_byte, ioctl_data} : {ioctl_data, r_pend_byte};
          w_sdr_be_nxt   = 2'b11;
          w_sdr_req_nxt  = 1'b1;
          w_wait_nxt     = 1'b1;
          w_pend_nxt     = 1'b0;
          w_state_nxt    = ST_SDR_WR;
        end
      end else if (w_hit) begin
        w_bram_wr_nxt   = 1'b1;
        w_bram_cs_nxt   = w_cs;
        w_bram_addr_nxt = w_offset;
        w_bram_data_nxt = ioctl_data;
      end else if (w_over) begin
        w_overflow_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_dl_q      <= 1'b0;
      r_pos       <= '0;
      r_pend      <= 1'b0;
      r_pend_byte <= '0;
      r_sdr_addr  <= '0;
      r_sdr_data  <= '0;
      r_sdr_be    <= '0;
      r_sdr_req   <= 1'b0;
      r_wait      <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
      r_bram_cs   <= '0;
      r_bram_wr   <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dl_q      <= ioctl_download;
      r_pos       <= w_pos_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_byte <= w_pend_byte_nxt;
      r_sdr_addr  <= w_sdr_addr_nxt;
      r_sdr_data  <= w_sdr_data_nxt;
      r_sdr_be    <= w_sdr_be_nxt;
      r_sdr_req   <= w_sdr_req_nxt;
      r_wait      <= w_wait_nxt;
      r_bram_addr <= w_bram_addr_nxt;
      r_bram_data <= w_bram_data_nxt;
      r_bram_cs   <= w_bram_cs_nxt;
      r_bram_wr   <= w_bram_wr_nxt;
      r_done      <= w_done_nxt;
      r_overflow  <= w_overflow_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign ioctl_wait = r_wait;
  assign sdr_addr   = r_sdr_addr;
  assign sdr_data   = r_sdr_data;
  assign sdr_be     = r_sdr_be;
  assign sdr_req    = r_sdr_req;
  assign bram_addr  = r_bram_addr;
  assign bram_data  = r_bram_data;
  assign bram_cs    = r_bram_cs;
  assign bram_wr    = r_bram_wr;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Scoreboard bench: two routers (normal and swapped lanes) with 4 SDRAM bytes and four 16-byte regions.
module tb_ioctl_rom_router;

  typedef struct packed {logic [24:0] addr; logic [15:0] data; logic [1:0] be;} sdr_t;
  typedef struct packed {logic [3:0] cs; logic [19:0] addr; logic [7:0] data;} bram_t;

  logic clk = 1'b0;
  logic rstn;
  logic h_dl, h_wr;
  logic [7:0] h_data;
  logic sel;
  int checks = 0;
  int errors = 0;

  logic a_dl, a_wr, a_wait, a_req, a_rdy, a_bwr, a_done, a_ovf, a_perr;
  logic [24:0] a_addr;
  logic [15:0] a_sdata;
  logic [1:0] a_be;
  logic [19:0] a_baddr;
  logic [7:0] a_bdata;
  logic [3:0] a_bcs;
  logic b_dl, b_wr, b_wait, b_req, b_rdy, b_bwr, b_done, b_ovf, b_perr;
  logic [24:0] b_addr;
  logic [15:0] b_sdata;
  logic [1:0] b_be;
  logic [19:0] b_baddr;
  logic [7:0] b_bdata;
  logic [3:0] b_bcs;
  logic cur_wait, cur_done;

  assign a_dl = h_dl & ~sel;
  assign a_wr = h_wr & ~sel;
  assign b_dl = h_dl & sel;
  assign b_wr = h_wr & sel;
  assign cur_wait = sel ? b_wait : a_wait;
  assign cur_done = sel ? b_done : a_done;

  always #5 clk = ~clk;

  ioctl_rom_router #(.ADDR_W(25), .SDR_BYTES(25'd4), .NUM_BRAM(4), .BRAM_ADDR_W(20),
                     .BRAM_BYTES({4{20'd16}}), .SWAP_BYTES(1'b0)) dut_a (
    .clk(clk), .RSTn(rstn), .ioctl_download(a_dl), .ioctl_wr(a_wr), .ioctl_data(h_data),
    .ioctl_wait(a_wait), .sdr_addr(a_addr), .sdr_data(a_sdata), .sdr_be(a_be),
    .sdr_req(a_req), .sdr_rdy(a_rdy), .bram_addr(a_baddr), .bram_data(a_bdata),
    .bram_cs(a_bcs), .bram_wr(a_bwr), .done(a_done), .overflow(a_ovf), .proto_err(a_perr));

  ioctl_rom_router #(.ADDR_W(25), .SDR_BYTES(25'd4), .NUM_BRAM(4), .BRAM_ADDR_W(20),
                     .BRAM_BYTES({4{20'd16}}), .SWAP_BYTES(1'b1)) dut_b (
    .clk(clk), .RSTn(rstn), .ioctl_download(b_dl), .ioctl_wr(b_wr), .ioctl_data(h_data),
    .ioctl_wait(b_wait), .sdr_addr(b_addr), .sdr_data(b_sdata), .sdr_be(b_be),
    .sdr_req(b_req), .sdr_rdy(b_rdy), .bram_addr(b_baddr), .bram_data(b_bdata),
    .bram_cs(b_bcs), .bram_wr(b_bwr), .done(b_done), .overflow(b_ovf), .proto_err(b_perr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SDRAM completion model: sdr_rdy pulses three cycles after the request appears.
  initial begin
    int cnt = 0;
    a_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (a_rdy) a_rdy = 1'b0;
      else if (a_req) begin cnt++; if (cnt == 3) begin a_rdy = 1'b1; cnt = 0; end end
      else cnt = 0;
    end
  end

  initial begin
    int cnt = 0;
    b_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_rdy) b_rdy = 1'b0;
      else if (b_req) begin cnt++; if (cnt == 3) begin b_rdy = 1'b1; cnt = 0; end end
      else cnt = 0;
    end
  end

  sdr_t qa[$], qb[$];
  bram_t qbr[$];
  sdr_t cur_a, cur_b;
  bram_t bexp;
  logic req_qa = 1'b0, req_qb = 1'b0, wr_q = 1'b0;

  always @(negedge clk) begin
    chk("a_wait_tracks_req", a_wait, a_req);
    chk("b_wait_tracks_req", b_wait, b_req);
    chk("b_bram_idle", b_bwr, 0);
    if (a_req && !req_qa) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_sdr_write: addr %0h data %0h be %0h, none expected", a_addr, a_sdata, a_be);
      end else cur_a = qa.pop_front();
    end
    if (a_req) begin
      chk("a_sdr_addr", a_addr, cur_a.addr);
      chk("a_sdr_data", a_sdata, cur_a.data);
      chk("a_sdr_be", a_be, cur_a.be);
    end
    req_qa = a_req;
    if (b_req && !req_qb) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_sdr_write: addr %0h data %0h be %0h, none expected", b_addr, b_sdata, b_be);
      end else cur_b = qb.pop_front();
    end
    if (b_req) begin
      chk("b_sdr_addr", b_addr, cur_b.addr);
      chk("b_sdr_data", b_sdata, cur_b.data);
      chk("b_sdr_be", b_be, cur_b.be);
    end
    req_qb = b_req;
    if (a_bwr) begin
      chk("a_bram_wr_one_cycle", wr_q, 0);
      if (qbr.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_bram_write: cs %0h addr %0h, none expected", a_bcs, a_baddr);
      end else begin
        bexp = qbr.pop_front();
        chk("a_bram_cs", a_bcs, bexp.cs);
        chk("a_bram_addr", a_baddr, bexp.addr);
        chk("a_bram_data", a_bdata, bexp.data);
      end
    end
    wr_q = a_bwr;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cur_wait && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout: ioctl_wait still 1 after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    h_wr = 1'b1; h_data = b;
    tick();
    h_wr = 1'b0;
    tick();
  endtask

  task automatic push_sdr(input logic [24:0] addr, input logic [15:0] data, input logic [1:0] be);
    sdr_t s;
    s.addr = addr; s.data = data; s.be = be;
    if (sel) qb.push_back(s); else qa.push_back(s);
  endtask

  task automatic start_dl();
    h_dl = 1'b1;
    tick();
    tick();
    chk("done_cleared_on_rise", cur_done, 0);
  endtask

  task automatic end_dl();
    int n = 0;
    wait_ready();
    h_dl = 1'b0;
    while (!cur_done && n < 100) begin tick(); n++; end
    chk("done_after_download", cur_done, 1);
  endtask

  initial begin
    bram_t be_item;
    int rel;
    rstn = 1'b0; h_dl = 1'b0; h_wr = 1'b0; h_data = 8'h00; sel = 1'b0;
    repeat (3) tick();
    chk("reset_ctrl", {a_req, a_wait, a_done, a_ovf, a_perr, a_bwr, a_bcs}, 0);
    chk("reset_sdr_addr", a_addr, 0);
    chk("reset_sdr_data_be", {a_sdata, a_be}, 0);
    chk("reset_bram_addr", a_baddr, 0);
    rstn = 1'b1;
    tick();

    // Word packing, even byte in low lane.
    push_sdr(25'd0, 16'h2211, 2'b11);
    push_sdr(25'd2, 16'h4433, 2'b11);
    start_dl();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    end_dl();

    // Odd-length stream with trailing flush, both lane orders.
    push_sdr(25'd0, 16'hB2A1, 2'b11);
    push_sdr(25'd2, 16'h00C3, 2'b01);
    start_dl();
    send(8'hA1); send(8'hB2); send(8'hC3);
    end_dl();
    sel = 1'b1;
    push_sdr(25'd0, 16'hA1B2, 2'b11);
    push_sdr(25'd2, 16'hC300, 2'b10);
    start_dl();
    send(8'hA1); send(8'hB2); send(8'hC3);
    end_dl();
    sel = 1'b0;
    tick();

    // Strobe while a write is outstanding is dropped without advancing pos.
    push_sdr(25'd0, 16'h6655, 2'b11);
    push_sdr(25'd2, 16'h9988, 2'b11);
    start_dl();
    chk("proto_err_cleared_on_rise", a_perr, 0);
    send(8'h55); send(8'h66);
    chk("wait_high_before_illegal_strobe", a_wait, 1);
    h_wr = 1'b1; h_data = 8'h77;
    tick();
    h_wr = 1'b0;
    chk("proto_err_set", a_perr, 1);
    send(8'h88); send(8'h99);
    end_dl();
    chk("proto_err_sticky", a_perr, 1);

    // BRAM routing across region boundaries, then overflow past the last region.
    push_sdr(25'd0, 16'hA4A5, 2'b11);
    push_sdr(25'd2, 16'hA6A7, 2'b11);
    for (int p = 4; p < 68; p++) begin
      rel = p - 4;
      be_item.cs = 4'b0001 << (rel / 16);
      be_item.addr = 20'(rel % 16);
      be_item.data = 8'(p) ^ 8'hA5;
      qbr.push_back(be_item);
    end
    start_dl();
    for (int p = 0; p < 68; p++) send(8'(p) ^ 8'hA5);
    chk("no_overflow_within_regions", a_ovf, 0);
    send(8'd68 ^ 8'hA5);
    chk("overflow_set", a_ovf, 1);
    send(8'd69 ^ 8'hA5);
    end_dl();
    chk("overflow_sticky", a_ovf, 1);
    start_dl();
    chk("overflow_cleared_on_rise", a_ovf, 0);
    end_dl();

    // Asynchronous reset in the middle of an SDRAM write, then a clean restart.
    push_sdr(25'd0, 16'h2010, 2'b11);
    start_dl();
    send(8'h10); send(8'h20);
    chk("req_before_reset", a_req, 1);
    #3 rstn = 1'b0;
    #1;
    chk("reset_async_req", a_req, 0);
    chk("reset_async_wait", a_wait, 0);
    chk("reset_async_done", a_done, 0);
    h_dl = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    push_sdr(25'd0, 16'h4231, 2'b11);
    start_dl();
    send(8'h31); send(8'h42);
    end_dl();
    repeat (3) tick();

    chk("sdr_queue_a_drained", qa.size(), 0);
    chk("sdr_queue_b_drained", qb.size(), 0);
    chk("bram_queue_drained", qbr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors so far", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
